// File: rtl/pll_reset_pkg.sv
// Shared constants for the PLL reset sequencer.
//   - FSM state encodings (exposed on the debug STATE output, so values are fixed)
//   - Default qualification/stagger delays derived from the 40 MHz system clock
package pll_reset_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT_LOCK = 2'd0;
  localparam state_t ST_STABILIZE = 2'd1;
  localparam state_t ST_STAGGER   = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  localparam int unsigned SYS_CLK_HZ = 40_000_000;

  // Whole-microsecond delay expressed in system clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned us);
    return us * (SYS_CLK_HZ / 1_000_000);
  endfunction

  // 100 us of continuous lock before the core leaves reset.
  localparam int unsigned LOCK_DELAY_DEFAULT = us_to_cycles(100);
  // 400 ns between core and peripheral release.
  localparam int unsigned STAGGER_DEFAULT    = 16;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// Ports:
//   clk_i   - destination clock
//   reset_i - synchronous active-high reset, clears the chain to 0
//   d_i     - asynchronous input bit
//   q_o     - synchronised output (last stage of the chain)
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL-lock-qualified reset sequencer for the 40 MHz system clock domain.
// Waits for the synchronised PLL lock to stay high for LOCK_DELAY cycles, releases
// the core reset, then releases the peripheral reset STAGGER cycles later. Any lock
// loss returns to WAIT_LOCK with both resets asserted; losses after the core has been
// released are counted (saturating) for the debug path.
// Ports:
//   clk_i           - 40 MHz system clock
//   reset_i         - synchronous active-high reset
//   locked_i        - PLL lock status, asynchronous to clk_i
//   rst_core_o      - active-high core reset, registered
//   rst_periph_o    - active-high peripheral reset, registered
//   ready_o         - high when both resets are released
//   lock_loss_cnt_o - saturating count of lock losses after core release
//   state_o         - FSM state for debug
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_DELAY  = LOCK_DELAY_DEFAULT,
  parameter int unsigned STAGGER     = STAGGER_DEFAULT,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOSS_W      = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              locked_i,
  output logic              rst_core_o,
  output logic              rst_periph_o,
  output logic              ready_o,
  output logic [LOSS_W-1:0] lock_loss_cnt_o,
  output logic [1:0]        state_o
);

  localparam logic [CNT_W-1:0] LockLast    = CNT_W'(LOCK_DELAY - 1);
  localparam logic [CNT_W-1:0] StaggerLast = CNT_W'(STAGGER - 1);

  logic locked_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rst_core_q, rst_core_d;
  logic              rst_periph_q, rst_periph_d;
  logic [LOSS_W-1:0] loss_q, loss_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_locked (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (locked_i),
    .q_o     (locked_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_core_d   = rst_core_q;
    rst_periph_d = rst_periph_q;
    loss_d       = loss_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst_core_d   = 1'b1;
        rst_periph_d = 1'b1;
        cnt_d        = '0;
        if (locked_s) begin
          state_d = ST_STABILIZE;
        end
      end

      // Losing lock here is not counted: the core never left reset.
      ST_STABILIZE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          state_d    = ST_STAGGER;
          cnt_d      = '0;
          rst_core_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STAGGER, ST_RUN: begin
        if (!locked_s) begin
          state_d      = ST_WAIT_LOCK;
          cnt_d        = '0;
          rst_core_d   = 1'b1;
          rst_periph_d = 1'b1;
          if (loss_q != {LOSS_W{1'b1}}) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end else if (state_q == ST_STAGGER) begin
          if (cnt_q == StaggerLast) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            rst_periph_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d      = ST_WAIT_LOCK;
        cnt_d        = '0;
        rst_core_d   = 1'b1;
        rst_periph_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      loss_q       <= loss_d;
    end
  end

  assign rst_core_o      = rst_core_q;
  assign rst_periph_o    = rst_periph_q;
  // Derived from the register so the two can never disagree.
  assign ready_o         = ~rst_periph_q;
  assign lock_loss_cnt_o = loss_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq with short delays
// (SYNC_STAGES=2, LOCK_DELAY=8, STAGGER=4, LOSS_W=4).
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       locked_i;
  logic       rst_core_o;
  logic       rst_periph_o;
  logic       ready_o;
  logic [3:0] lock_loss_cnt_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES (2),
    .LOCK_DELAY  (8),
    .STAGGER     (4),
    .CNT_W       (16),
    .LOSS_W      (4)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .locked_i        (locked_i),
    .rst_core_o      (rst_core_o),
    .rst_periph_o    (rst_periph_o),
    .ready_o         (ready_o),
    .lock_loss_cnt_o (lock_loss_cnt_o),
    .state_o         (state_o)
  );

  // Invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (ready_o !== ~rst_periph_o) begin
        n_fail++;
        $display("FAIL inv_ready: ready=%b rst_periph=%b, required ready==~rst_periph",
                 ready_o, rst_periph_o);
      end
      n_checks++;
      if (rst_periph_o === 1'b0 && rst_core_o !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_order: rst_periph=0 with rst_core=%b, required rst_core=0",
                 rst_core_o);
      end
    end
  end

  // Advance one clock edge and settle just after it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    locked_i = 1'b0;
    tick(3);
    reset_i  = 1'b0;
  endtask

  // Call with locked_i just raised and the synchronised lock still low.
  // Edge numbering is relative to the first edge that samples the raised LOCKED.
  task automatic lock_sequence(input string tag);
    tick(2);
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++; $display("FAIL %s_e2_state: got %0d required 0", tag, state_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd1 || rst_core_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_e3: state=%0d rst_core=%b required state=1 rst_core=1",
                         tag, state_o, rst_core_o);
    end
    tick(7);
    n_checks++;
    if (state_o !== 2'd1 || rst_core_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_e10: state=%0d rst_core=%b required state=1 rst_core=1",
                         tag, state_o, rst_core_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd2 || rst_core_o !== 1'b0 || rst_periph_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_e11: state=%0d rst_core=%b rst_periph=%b required 2/0/1",
               tag, state_o, rst_core_o, rst_periph_o);
    end
    tick(3);
    n_checks++;
    if (state_o !== 2'd2 || rst_periph_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_e14: state=%0d rst_periph=%b ready=%b required 2/1/0",
               tag, state_o, rst_periph_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd3 || rst_periph_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_e15: state=%0d rst_periph=%b ready=%b required 3/0/1",
               tag, state_o, rst_periph_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd3 || rst_core_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_e16_hold: state=%0d rst_core=%b ready=%b required 3/0/1",
               tag, state_o, rst_core_o, ready_o);
    end
  endtask

  task automatic test_reset();
    reset_i  = 1'b1;
    locked_i = 1'b0;
    tick(3);
    chk_en = 1'b1;
    n_checks++;
    if (rst_core_o !== 1'b1 || rst_periph_o !== 1'b1 || ready_o !== 1'b0 ||
        lock_loss_cnt_o !== 4'd0 || state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_vals: core=%b periph=%b ready=%b loss=%0d state=%0d required 1/1/0/0/0",
               rst_core_o, rst_periph_o, ready_o, lock_loss_cnt_o, state_o);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_checks++;
      if (state_o !== 2'd0 || rst_core_o !== 1'b1 || rst_periph_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold_%0d: state=%0d core=%b periph=%b required 0/1/1",
                 i, state_o, rst_core_o, rst_periph_o);
      end
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    locked_i = 1'b1;
    lock_sequence("clean");
    n_checks++;
    if (lock_loss_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL clean_loss: got %0d required 0", lock_loss_cnt_o);
    end
  endtask

  task automatic test_glitch_stabilize();
    do_reset();
    locked_i = 1'b1;
    tick(3);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++; $display("FAIL glitch_e3_state: got %0d required 1", state_o);
    end
    tick(2);
    locked_i = 1'b0;   // low across edges 6 and 7
    tick(2);
    n_checks++;
    if (state_o !== 2'd1 || rst_core_o !== 1'b1) begin
      n_fail++; $display("FAIL glitch_e7: state=%0d core=%b required 1/1", state_o, rst_core_o);
    end
    locked_i = 1'b1;
    tick(1);
    n_checks++;
    if (state_o !== 2'd0 || rst_core_o !== 1'b1 || lock_loss_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL glitch_e8: state=%0d core=%b loss=%0d required 0/1/0",
                         state_o, rst_core_o, lock_loss_cnt_o);
    end
    tick(2);
    n_checks++;
    if (state_o !== 2'd1) begin
      n_fail++; $display("FAIL glitch_e10_state: got %0d required 1", state_o);
    end
    for (int e = 11; e <= 17; e++) begin
      tick(1);
      n_checks++;
      if (rst_core_o !== 1'b1) begin
        n_fail++; $display("FAIL glitch_core_e%0d: got %b required 1", e, rst_core_o);
      end
    end
    tick(1);
    n_checks++;
    if (rst_core_o !== 1'b0 || state_o !== 2'd2) begin
      n_fail++; $display("FAIL glitch_e18: core=%b state=%0d required 0/2", rst_core_o, state_o);
    end
    tick(4);
    n_checks++;
    if (ready_o !== 1'b1 || lock_loss_cnt_o !== 4'd0) begin
      n_fail++; $display("FAIL glitch_e22: ready=%b loss=%0d required 1/0", ready_o,
                         lock_loss_cnt_o);
    end
  endtask

  task automatic test_loss_run();
    do_reset();
    locked_i = 1'b1;
    lock_sequence("run_first");
    locked_i = 1'b0;
    tick(2);
    n_checks++;
    if (state_o !== 2'd3 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL loss_run_e2: state=%0d ready=%b required 3/1", state_o, ready_o);
    end
    tick(1);
    n_checks++;
    if (state_o !== 2'd0 || rst_core_o !== 1'b1 || rst_periph_o !== 1'b1 ||
        ready_o !== 1'b0 || lock_loss_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL loss_run_e3: state=%0d core=%b periph=%b ready=%b loss=%0d required 0/1/1/0/1",
               state_o, rst_core_o, rst_periph_o, ready_o, lock_loss_cnt_o);
    end
    locked_i = 1'b1;
    lock_sequence("relock");
    n_checks++;
    if (lock_loss_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL relock_loss: got %0d required 1", lock_loss_cnt_o);
    end
  endtask

  task automatic test_loss_stagger();
    do_reset();
    locked_i = 1'b1;
    tick(11);
    n_checks++;
    if (state_o !== 2'd2) begin
      n_fail++; $display("FAIL stag_e11_state: got %0d required 2", state_o);
    end
    locked_i = 1'b0;
    tick(3);
    n_checks++;
    if (state_o !== 2'd0 || rst_core_o !== 1'b1 || rst_periph_o !== 1'b1 ||
        lock_loss_cnt_o !== 4'd1) begin
      n_fail++;
      $display("FAIL stag_loss: state=%0d core=%b periph=%b loss=%0d required 0/1/1/1",
               state_o, rst_core_o, rst_periph_o, lock_loss_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      locked_i = 1'b1;
      lock_sequence("sat");
      locked_i = 1'b0;
      tick(3);
      exp_cnt = (i > 15) ? 15 : i;
      n_checks++;
      if (state_o !== 2'd0 || lock_loss_cnt_o !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_%0d: state=%0d loss=%0d required 0/%0d",
                 i, state_o, lock_loss_cnt_o, exp_cnt);
      end
    end
    tick(5);
    n_checks++;
    if (lock_loss_cnt_o !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold: got %0d required 15", lock_loss_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    locked_i = 1'b1;
    lock_sequence("mid_pre");
    locked_i = 1'b0;
    tick(3);
    locked_i = 1'b1;
    tick(12);
    n_checks++;
    if (state_o !== 2'd2 || rst_core_o !== 1'b0 || lock_loss_cnt_o !== 4'd1) begin
      n_fail++; $display("FAIL mid_setup: state=%0d core=%b loss=%0d required 2/0/1",
                         state_o, rst_core_o, lock_loss_cnt_o);
    end
    reset_i = 1'b1;
    tick(1);
    n_checks++;
    if (rst_core_o !== 1'b1 || rst_periph_o !== 1'b1 || state_o !== 2'd0 ||
        lock_loss_cnt_o !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: core=%b periph=%b state=%0d loss=%0d required 1/1/0/0",
               rst_core_o, rst_periph_o, state_o, lock_loss_cnt_o);
    end
    // LOCKED stays high through reset exit; the sync chain was cleared.
    reset_i = 1'b0;
    lock_sequence("mid_restart");
  endtask

  initial begin
    reset_i  = 1'b1;
    locked_i = 1'b0;
    test_reset();
    test_clean_lock();
    test_glitch_stabilize();
    test_loss_run();
    test_loss_stagger();
    test_saturation();
    test_reset_mid();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
